edge_stream_core: RTL and testbench
===================================

Name: edge_stream_core

Overview:
Parametrised streaming Sobel edge engine, the next generation of the fixed edge-detection datapath. It accepts one pixel per cycle over a valid/ready handshake and buffers two image lines internally. It emits one edge pixel per input pixel, either saturated gradient magnitude or a binary threshold map. It sits between the input peripheral and downstream suppression/threshold stages, and drains its line-buffer latency at end of frame without needing extra input.

Parameters:
PIX_W, 8, pixel bit width (input and output)
IMG_W, 640, pixels per line (>=4)
IMG_H, 480, lines per frame (>=3)
MAG_W, PIX_W+4, internal magnitude width, derived, not overridable

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  permits a new frame to start
mode  in  1  0 = saturated magnitude, 1 = binary threshold
threshold  in  MAG_W  threshold for mode 1
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid&&in_ready
in_pixel  in  PIX_W  raster-order pixel
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_pixel  out  PIX_W  edge pixel
out_last  out  1  marks last output pixel of frame
busy  out  1  frame in progress (RUN or FLUSH)

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pixel=0, out_last=0, busy=0. Reset also clears the FSM to IDLE and clears all counters, pipeline valids and line buffers. Reset mid-frame discards the partial frame with no further outputs.
- advance = !out_valid || out_ready. Every pipeline register updates only on advance.
- FSM:
  - IDLE: in_ready=0. Go to RUN when enable=1.
  - RUN: in_ready=advance. Each accepted pixel increments the input index. On acceptance of pixel IMG_W*IMG_H-1, go to FLUSH.
  - FLUSH: in_ready=0. On each advance cycle, inject one internal zero pixel, IMG_W+1 injections in total. After the last injection, go to IDLE.
- mode and threshold are latched on acceptance of pixel 0 of a frame. Changes mid-frame have no effect until the next frame.
- Window: two line buffers of IMG_W×PIX_W plus a 3×3 shift window, keyed by linear index. Output index k is produced when input (or injected) index k+IMG_W+1 enters the window.
- Latency: pixel accepted at cycle t drives its output at t+2 when no stall occurs (two register stages).
  - Stage 1: gx, gy.
  - Stage 2: magnitude, border, mode.
- Arithmetic:
  - gx = (p02+2·p12+p22)-(p00+2·p10+p20); gy = (p20+2·p21+p22)-(p00+2·p01+p02). Both are signed MAG_W bits, no overflow.
  - mag = |gx|+|gy|, unsigned MAG_W bits.
  - mode 0: out_pixel = min(mag, 2^PIX_W-1).
  - mode 1: out_pixel = all-ones if mag>=threshold, else 0.
- Border: output row 0, row IMG_H-1, column 0 or column IMG_W-1 forces out_pixel=0. This overrides wrap-around window contents.
- out_last=1 only with output index IMG_W*IMG_H-1, qualified by out_valid.
- Exactly IMG_W*IMG_H outputs per frame.
- out_valid/out_pixel hold stable while out_valid&&!out_ready.
- A new frame may begin once the FSM returns to IDLE with enable high. The first in_ready of the next frame follows the cycle after the last FLUSH injection.

Test Plan (IMG_W=8, IMG_H=6, PIX_W=8):
- Flat image, all 100, mode 0, out_ready=1 -> 48 outputs, all 0. out_last only on the 48th. busy returns to 0 after it.
- Vertical step (cols 0-3=0, cols 4-7=200), mode 0 -> rows 1-4: cols 3 and 4 = 255 (mag 800 saturated), all other pixels 0.
- Same step, mode 1, threshold=500 -> cols 3,4 of rows 1-4 = 255, else 0. With threshold=801 -> all 0.
- Step image with out_ready randomly 50% low -> output sequence identical to the unstalled run. out_pixel is stable while stalled, and in_ready=0 whenever out_valid&&!out_ready.
- mode toggled 0→1 at pixel 20 -> whole frame uses mode 0. The next frame, started with mode=1, uses mode 1.
- Reset asserted at input pixel 30 -> next cycle: out_valid=0, busy=0, in_ready=0. A fresh flat frame after reset yields exactly 48 zero outputs.

Source files
------------

// File: rtl/edge_stream_if.sv
// Pixel stream bundle for the Sobel edge engine.
// A beat moves on any rising edge where valid && ready are both high; valid must not depend on ready.
interface edge_stream_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_last
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/edge_stream_core.sv
// Streaming 3x3 Sobel edge engine: two line buffers, a 2-stage gradient pipeline,
// and a self-driven flush that drains the line-buffer latency at end of frame.
module edge_stream_core #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [PIX_W+3:0] threshold,
  edge_stream_if.slave     strm,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  localparam int MAG_W = PIX_W + 4;
  localparam int N     = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(N + IMG_W + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [MAG_W-1:0] PIX_MAX = MAG_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic             busy_q;
  logic             mode_q;
  logic [MAG_W-1:0] thr_q;

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [PIX_W-1:0] col_new [3];

  logic             s1_valid_q, s1_border_q, s1_last_q;
  logic [MAG_W-1:0] s1_gx_q, s1_gy_q;
  logic             s1_border_d, s1_last_d;
  logic [MAG_W-1:0] gx_d, gy_d;

  logic             out_valid_q, out_last_q;
  logic [PIX_W-1:0] out_pixel_q, pix_val;
  logic [MAG_W-1:0] abs_x, abs_y, mag;

  logic advance, in_ready, accept, inject, push, produce;
  logic [PIX_W-1:0] new_pix;

  function automatic logic [MAG_W-1:0] tri_sum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
    return MAG_W'(a) + (MAG_W'(b) << 1) + MAG_W'(c);
  endfunction

  assign advance  = !out_valid_q || strm.out_ready;
  assign in_ready = (state_q == ST_RUN) && advance;
  assign accept   = strm.in_valid && in_ready;
  assign inject   = (state_q == ST_FLUSH) && advance;
  assign push     = accept || inject;
  assign new_pix  = accept ? strm.in_pixel : '0;
  // The window is centred on output k once input k+IMG_W+1 enters it.
  assign produce  = push && (idx_q >= IDX_W'(IMG_W + 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_col_d  = in_col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (accept && idx_q == IDX_W'(N - 1)) state_d = ST_FLUSH;
      ST_FLUSH: if (inject && idx_q == IDX_W'(N + IMG_W)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (push) begin
      idx_d    = idx_q + 1'b1;
      in_col_d = (in_col_q == COL_W'(IMG_W - 1)) ? '0 : in_col_q + 1'b1;
      if (state_d == ST_IDLE) begin
        idx_d    = '0;
        in_col_d = '0;
      end
    end
    if (produce) begin
      out_col_d = (out_col_q == COL_W'(IMG_W - 1)) ? '0 : out_col_q + 1'b1;
      if (out_col_q == COL_W'(IMG_W - 1))
        out_row_d = (out_row_q == ROW_W'(IMG_H - 1)) ? '0 : out_row_q + 1'b1;
    end
  end

  // Next window: shift left, new column = {two lines back, one line back, incoming}.
  always_comb begin
    col_new[0] = lb1_q[in_col_q];
    col_new[1] = lb0_q[in_col_q];
    col_new[2] = new_pix;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
      win_d[r][2] = col_new[r];
    end
  end

  always_comb begin
    gx_d = tri_sum(win_d[0][2], win_d[1][2], win_d[2][2])
         - tri_sum(win_d[0][0], win_d[1][0], win_d[2][0]);
    gy_d = tri_sum(win_d[2][0], win_d[2][1], win_d[2][2])
         - tri_sum(win_d[0][0], win_d[0][1], win_d[0][2]);
    s1_border_d = (out_row_q == '0) || (out_row_q == ROW_W'(IMG_H - 1)) ||
                  (out_col_q == '0) || (out_col_q == COL_W'(IMG_W - 1));
    s1_last_d   = (out_row_q == ROW_W'(IMG_H - 1)) && (out_col_q == COL_W'(IMG_W - 1));
  end

  always_comb begin
    abs_x   = s1_gx_q[MAG_W-1] ? (~s1_gx_q + 1'b1) : s1_gx_q;
    abs_y   = s1_gy_q[MAG_W-1] ? (~s1_gy_q + 1'b1) : s1_gy_q;
    mag     = abs_x + abs_y;
    pix_val = '0;
    if (!s1_valid_q || s1_border_q) pix_val = '0;
    else if (mode_q)                pix_val = (mag >= thr_q) ? '1 : '0;
    else                            pix_val = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_col_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      thr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_border_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_col_q  <= in_col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      busy_q    <= (state_d != ST_IDLE);
      if (push) begin
        win_q           <= win_d;
        lb1_q[in_col_q] <= lb0_q[in_col_q];
        lb0_q[in_col_q] <= new_pix;
      end
      if (accept && idx_q == '0) begin
        mode_q <= mode;
        thr_q  <= threshold;
      end
      if (advance) begin
        s1_valid_q  <= produce;
        s1_gx_q     <= gx_d;
        s1_gy_q     <= gy_d;
        s1_border_q <= s1_border_d;
        s1_last_q   <= s1_last_d;
        out_valid_q <= s1_valid_q;
        out_pixel_q <= pix_val;
        out_last_q  <= s1_valid_q && s1_last_q;
      end
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_pixel = out_pixel_q;
  assign strm.out_last  = out_last_q;
  assign busy           = busy_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_edge_stream_core.sv
// Bench for edge_stream_core on an 8x6 image: table of frame scenarios plus
// hand-written mode-latch and mid-frame reset sequences, all against a 2-D Sobel model.
module tb_edge_stream_core;
  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NP = W * H;

  typedef struct {
    int kind;    // 0 flat 100, 1 vertical step, 2 random
    bit mode;
    int thr;
    int stall;   // percent of cycles with out_ready low
    int exp_nz;  // expected count of non-zero outputs, -1 = model only
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] threshold = '0;
  logic        busy;
  logic [1:0]  state_dbg;

  edge_stream_if #(.PIX_W(PW)) bus ();

  edge_stream_core #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .threshold (threshold),
    .strm      (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int img [NP];
  logic [PW-1:0] exp_q [$];
  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int px(int r, int c);
    return img[r * W + c];
  endfunction

  // Plain 2-D Sobel with border zeroing.
  function automatic int model_px(int k, bit m, int thr);
    int r, c, gx, gy, mag;
    r = k / W;
    c = k % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
       - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
    gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
       - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m) return (mag >= thr) ? 255 : 0;
    return (mag > 255) ? 255 : mag;
  endfunction

  task automatic build_image(input int kind);
    for (int i = 0; i < NP; i++) begin
      case (kind)
        0:       img[i] = 100;
        1:       img[i] = ((i % W) >= 4) ? 200 : 0;
        default: img[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic run_frame(input vec_t v, input bit m1, input int thr1,
                           input int change_at, input int reset_at);
    int pix, nout, nz, cyc;
    bit done, held_v;
    logic [PW-1:0] held_p;
    logic [PW-1:0] e;
    build_image(v.kind);
    exp_q.delete();
    for (int k = 0; k < NP; k++) exp_q.push_back(PW'(model_px(k, v.mode, v.thr)));
    pix = 0; nout = 0; nz = 0; cyc = 0; done = 0; held_v = 0; held_p = '0;
    @(negedge clk);
    mode = v.mode;
    threshold = 12'(v.thr);
    enable = 1'b1;
    while (!done) begin
      if (pix > 0) enable = 1'b0;
      if (pix >= change_at) begin
        mode = m1;
        threshold = 12'(thr1);
      end
      if (pix == reset_at) begin
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        done = 1;
      end else begin
        bus.in_valid  = (pix < NP) && ($urandom_range(0, 99) >= v.stall / 2);
        bus.in_pixel  = bus.in_valid ? PW'(img[pix]) : '0;
        bus.out_ready = ($urandom_range(0, 99) >= v.stall);
        #1;
        if (held_v) begin
          check("hold_valid", int'(bus.out_valid), 1);
          check("hold_pixel", int'(bus.out_pixel), int'(held_p));
        end
        if (bus.out_valid && !bus.out_ready) check("stall_in_ready", int'(bus.in_ready), 0);
        held_v = bus.out_valid && !bus.out_ready;
        held_p = bus.out_pixel;
        if (bus.in_valid && bus.in_ready) pix++;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pixel", int'(bus.out_pixel), int'(e));
          end
          check("out_last", int'(bus.out_last), (nout == NP - 1) ? 1 : 0);
          if (bus.out_pixel != 0) nz++;
          nout++;
          if (nout == NP) begin
            check("busy_end", int'(busy), 0);
            done = 1;
          end
        end
        cyc++;
        if (!done && cyc > 3000) begin
          check("timeout_outputs", nout, NP);
          done = 1;
        end
        if (!done) @(negedge clk);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (reset_at >= NP && v.exp_nz >= 0) check("nonzero_count", nz, v.exp_nz);
    repeat (3) @(negedge clk);
    #1;
    check("no_extra", int'(bus.out_valid), 0);
  endtask

  initial begin
    vec_t hv;
    vecs[0] = '{kind: 0, mode: 1'b0, thr: 0,   stall: 0,  exp_nz: 0};
    vecs[1] = '{kind: 1, mode: 1'b0, thr: 0,   stall: 0,  exp_nz: 8};
    vecs[2] = '{kind: 1, mode: 1'b1, thr: 500, stall: 0,  exp_nz: 8};
    vecs[3] = '{kind: 1, mode: 1'b1, thr: 801, stall: 0,  exp_nz: 0};
    vecs[4] = '{kind: 1, mode: 1'b1, thr: 800, stall: 0,  exp_nz: 8};
    vecs[5] = '{kind: 1, mode: 1'b0, thr: 0,   stall: 50, exp_nz: 8};
    vecs[6] = '{kind: 2, mode: 1'b0, thr: 0,   stall: 30, exp_nz: -1};
    vecs[7] = '{kind: 2, mode: 1'b1, thr: 300, stall: 50, exp_nz: -1};
    vecs[8] = '{kind: 0, mode: 1'b1, thr: 0,   stall: 20, exp_nz: 24};

    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_pixel", int'(bus.out_pixel), 0);
    check("reset_out_last", int'(bus.out_last), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_frame(vecs[i], vecs[i].mode, vecs[i].thr, 1000, 1000);

    // Mid-frame change to mode 1 / high threshold must not take effect.
    hv = '{kind: 1, mode: 1'b0, thr: 900, stall: 25, exp_nz: 8};
    run_frame(hv, 1'b1, 900, 20, 1000);
    // Next frame starts in mode 1 and must use it.
    hv = '{kind: 1, mode: 1'b1, thr: 900, stall: 0, exp_nz: 0};
    run_frame(hv, 1'b1, 900, 1000, 1000);
    // Threshold changed mid-frame is also ignored.
    hv = '{kind: 1, mode: 1'b1, thr: 500, stall: 0, exp_nz: 8};
    run_frame(hv, 1'b1, 2000, 20, 1000);

    hv = '{kind: 0, mode: 1'b0, thr: 0, stall: 0, exp_nz: -1};
    run_frame(hv, 1'b0, 0, 1000, 30);
    hv = '{kind: 0, mode: 1'b0, thr: 0, stall: 0, exp_nz: 0};
    run_frame(hv, 1'b0, 0, 1000, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
